// File: rtl/therm_pkg.sv
// Shared types and default widths for the binary-to-thermometer generator.
// Optional bubble injection is enabled with the THERM_BUBBLE_INJECT_EN macro.
package therm_pkg;

  localparam int unsigned BinLengthDef    = 9;
  localparam int unsigned ThermLengthDef  = 128;
  localparam int unsigned RepeatLengthDef = 16;

  // Repeat counter is fixed at 16 bits so any legal hold length (1..65535) fits.
  localparam int unsigned RepCntW = 16;

  typedef enum logic {
    StIdle,
    StSweep
  } state_e;

endpackage

// File: rtl/bin2therm_enc.sv
// Saturating binary-to-thermometer encoder followed by the first pipeline register.
// With THERM_BUBBLE_INJECT_EN defined, one selected bit can be inverted on entry.
module bin2therm_enc
  import therm_pkg::*;
#(
  parameter int unsigned code_width   = BinLengthDef + 1,
  parameter int unsigned therm_length = ThermLengthDef
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [code_width-1:0]               code_i,
  input  logic                                valid_i,
  input  logic                                last_i,
  input  logic                                sweep_i,
`ifdef THERM_BUBBLE_INJECT_EN
  input  logic                                bubble_en_i,
  input  logic [$clog2(therm_length)-1:0]     bubble_pos_i,
`endif
  output logic [therm_length-1:0]             thermo_o,
  output logic                                valid_o,
  output logic                                last_o,
  output logic                                sweep_o
);

  logic [therm_length-1:0] enc_value;
  logic [therm_length-1:0] thermo_q, thermo_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic                    sweep_q, sweep_d;

  // Codes at or above therm_length naturally saturate to all ones.
  always_comb begin
    enc_value = '0;
    for (int unsigned k = 0; k < therm_length; k++) begin
      enc_value[k] = (32'(code_i) > k);
    end
`ifdef THERM_BUBBLE_INJECT_EN
    if (bubble_en_i) begin
      enc_value[bubble_pos_i] = ~enc_value[bubble_pos_i];
    end
`endif
  end

  always_comb begin
    thermo_d = valid_i ? enc_value : thermo_q;
    valid_d  = valid_i;
    last_d   = valid_i & last_i;
    sweep_d  = valid_i & sweep_i;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      thermo_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      sweep_q  <= 1'b0;
    end else begin
      thermo_q <= thermo_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      sweep_q  <= sweep_d;
    end
  end

  assign thermo_o = thermo_q;
  assign valid_o  = valid_q;
  assign last_o   = last_q;
  assign sweep_o  = sweep_q;

endmodule

// File: rtl/bin2therm_gen.sv
// Thermometer code generator: handshaked encode path plus a code-density sweep engine.
// Define THERM_BUBBLE_INJECT_EN to add bubble_en/bubble_pos fault-injection inputs.
module bin2therm_gen
  import therm_pkg::*;
#(
  parameter int unsigned bin_length    = BinLengthDef,
  parameter int unsigned therm_length  = ThermLengthDef,
  parameter int unsigned repeat_length = RepeatLengthDef
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [bin_length-1:0]           bin_in,
  input  logic                            valid_in,
  output logic                            ready_out,
  input  logic                            start_sweep,
`ifdef THERM_BUBBLE_INJECT_EN
  input  logic                            bubble_en,
  input  logic [$clog2(therm_length)-1:0] bubble_pos,
`endif
  output logic [therm_length-1:0]         thermo,
  output logic                            valid_thermo,
  output logic                            sweep_busy,
  output logic                            sweep_done
);

  localparam int unsigned CodeW = bin_length + 1;

  state_e               state_q, state_d;
  logic [CodeW-1:0]     code_cnt_q, code_cnt_d;
  logic [RepCntW-1:0]   rep_cnt_q, rep_cnt_d;
  logic                 rep_wrap, sweep_last;

  logic                 issue, issue_last, issue_sweep;
  logic [CodeW-1:0]     issue_code;

  logic [therm_length-1:0] s1_thermo;
  logic                    s1_valid, s1_last, s1_sweep;

  logic [therm_length-1:0] thermo_q, thermo_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic                    s2_sweep_q, s2_sweep_d;

  assign rep_wrap   = (rep_cnt_q == RepCntW'(repeat_length - 1));
  assign sweep_last = rep_wrap && (code_cnt_q == CodeW'(therm_length));

  // The start cycle issues code 0 itself, so the first sweep code lands two cycles later.
  always_comb begin
    state_d     = state_q;
    code_cnt_d  = code_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    issue       = 1'b0;
    issue_last  = 1'b0;
    issue_sweep = 1'b0;
    issue_code  = '0;
    ready_out   = (state_q == StIdle) && !start_sweep;

    unique case (state_q)
      StIdle: begin
        if (start_sweep) begin
          issue       = 1'b1;
          issue_sweep = 1'b1;
          issue_code  = code_cnt_q;
          state_d     = StSweep;
          if (rep_wrap) begin
            rep_cnt_d  = '0;
            code_cnt_d = code_cnt_q + 1'b1;
          end else begin
            rep_cnt_d  = rep_cnt_q + 1'b1;
          end
        end else if (valid_in) begin
          issue      = 1'b1;
          issue_code = CodeW'(bin_in);
        end
      end
      StSweep: begin
        issue       = 1'b1;
        issue_sweep = 1'b1;
        issue_code  = code_cnt_q;
        if (sweep_last) begin
          issue_last = 1'b1;
          state_d    = StIdle;
          code_cnt_d = '0;
          rep_cnt_d  = '0;
        end else if (rep_wrap) begin
          rep_cnt_d  = '0;
          code_cnt_d = code_cnt_q + 1'b1;
        end else begin
          rep_cnt_d  = rep_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      code_cnt_q <= '0;
      rep_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      code_cnt_q <= code_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
    end
  end

  bin2therm_enc #(
    .code_width   (CodeW),
    .therm_length (therm_length)
  ) u_enc (
    .clock        (clock),
    .reset        (reset),
    .code_i       (issue_code),
    .valid_i      (issue),
    .last_i       (issue_last),
    .sweep_i      (issue_sweep),
`ifdef THERM_BUBBLE_INJECT_EN
    .bubble_en_i  (bubble_en),
    .bubble_pos_i (bubble_pos),
`endif
    .thermo_o     (s1_thermo),
    .valid_o      (s1_valid),
    .last_o       (s1_last),
    .sweep_o      (s1_sweep)
  );

  // Second stage: thermo holds its last value through invalid cycles.
  always_comb begin
    thermo_d   = s1_valid ? s1_thermo : thermo_q;
    valid_d    = s1_valid;
    done_d     = s1_last;
    s2_sweep_d = s1_sweep;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      thermo_q   <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      s2_sweep_q <= 1'b0;
    end else begin
      thermo_q   <= thermo_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      s2_sweep_q <= s2_sweep_d;
    end
  end

  assign thermo       = thermo_q;
  assign valid_thermo = valid_q;
  assign sweep_done   = done_q;
  // Busy covers the FSM plus sweep codes still draining through both stages.
  assign sweep_busy   = (state_q == StSweep) | s1_sweep | s2_sweep_q;

endmodule

// File: tb/tb_bin2therm_gen.sv
// Scoreboard bench for bin2therm_gen: driver predicts responses from a cycle-level
// behavioural model; a negedge monitor pops and compares whatever the DUT presents.
module tb_bin2therm_gen;

  localparam int TL      = 128;
  localparam int RL      = 16;
  localparam int SWEEP_N = (TL + 1) * RL;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [8:0]   bin_in = '0;
  logic         valid_in = 1'b0;
  logic         start_sweep = 1'b0;
  logic         ready_out;
  logic [127:0] thermo;
  logic         valid_thermo;
  logic         sweep_busy;
  logic         sweep_done;

  bin2therm_gen dut (
    .clock        (clock),
    .reset        (reset),
    .bin_in       (bin_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .start_sweep  (start_sweep),
    .thermo       (thermo),
    .valid_thermo (valid_thermo),
    .sweep_busy   (sweep_busy),
    .sweep_done   (sweep_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [127:0] th;
    bit           done;
    int           cyc;
  } item_t;

  item_t        sbq[$];
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  int           idle_from = 0;
  int           busy_lo = 0;
  int           busy_hi = -1;
  logic [127:0] last_th = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [127:0] exp_therm(input int b);
    logic [127:0] one;
    one = 128'd1;
    if (b >= TL) return '1;
    return (one << b) - one;
  endfunction

  function automatic logic [8:0] pick_bin();
    case ($urandom_range(0, 5))
      0:       return 9'd0;
      1:       return 9'd127;
      2:       return 9'd128;
      3:       return 9'd129;
      4:       return 9'd511;
      default: return 9'($urandom_range(0, 511));
    endcase
  endfunction

  // One clock cycle of stimulus; the model decides acceptance on its own.
  task automatic step(input bit v, input logic [8:0] b, input bit s);
    item_t it;
    bit    idle;
    @(posedge clock);
    #1;
    valid_in    = v;
    bin_in      = b;
    start_sweep = s;
    idle        = (cyc >= idle_from);
    #1;
    check("ready_out", ready_out, idle && !s);
    if (idle && s) begin
      for (int i = 0; i < SWEEP_N; i++) begin
        it.th   = exp_therm(i / RL);
        it.done = (i == SWEEP_N - 1);
        it.cyc  = cyc + 2 + i;
        sbq.push_back(it);
      end
      if (cyc + 1 > busy_hi + 1) busy_lo = cyc + 1;
      busy_hi   = cyc + SWEEP_N + 1;
      idle_from = cyc + SWEEP_N;
    end else if (idle && v) begin
      it.th   = exp_therm(int'(b));
      it.done = 1'b0;
      it.cyc  = cyc + 2;
      sbq.push_back(it);
    end
  endtask

  task automatic apply_reset(input int n);
    @(posedge clock);
    #1;
    reset       = 1'b1;
    valid_in    = 1'b0;
    start_sweep = 1'b0;
    sbq.delete();
    busy_hi = -1;
    last_th = '0;
    repeat (n) @(posedge clock);
    #1;
    reset     = 1'b0;
    idle_from = cyc;
  endtask

  always @(negedge clock) begin : mon
    item_t it;
    if (reset) begin
      check("rst_thermo", thermo, '0);
      check("rst_valid", valid_thermo, 0);
      check("rst_busy", sweep_busy, 0);
      check("rst_done", sweep_done, 0);
    end else begin
      check("sweep_busy", sweep_busy, (cyc >= busy_lo) && (cyc <= busy_hi));
      if (valid_thermo) begin
        if (sbq.size() == 0) begin
          check("valid_thermo", valid_thermo, 0);
        end else begin
          it = sbq.pop_front();
          check("latency", cyc, it.cyc);
          check("thermo", thermo, it.th);
          check("sweep_done", sweep_done, it.done);
          last_th = it.th;
        end
      end else begin
        check("valid_thermo", valid_thermo, (sbq.size() > 0) && (sbq[0].cyc <= cyc));
        check("thermo_hold", thermo, last_th);
        check("done_idle", sweep_done, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d act=running exp=finished", cyc);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    reset     = 1'b0;
    idle_from = cyc;

    // Single transfer then idle gap
    step(1, 9'd5, 0);
    repeat (4) step(0, 9'd0, 0);

    // Boundary codes back to back
    step(1, 9'd0, 0);
    step(1, 9'd128, 0);
    step(1, 9'd300, 0);
    repeat (4) step(0, 9'd0, 0);

    // Start beats valid in the same cycle; junk inputs during the sweep are ignored
    step(1, 9'd77, 1);
    for (int i = 0; i < SWEEP_N + 4; i++) begin
      step(1'($urandom_range(0, 1)), pick_bin(), 1'($urandom_range(0, 1)));
    end

    // Random mix of transfers, idle cycles and sweeps
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      step(r < 700, pick_bin(), r < 2);
    end
    while (cyc < idle_from) step(0, 9'd0, 0);

    // Abort a sweep with reset, then a plain transfer must still work
    step(0, 9'd0, 1);
    repeat (499) step(0, 9'd0, 0);
    apply_reset(2);
    step(1, 9'd5, 0);
    step(1, 9'd200, 0);
    repeat (4) step(0, 9'd0, 0);

    for (int i = 0; i < 3000 && sbq.size() > 0; i++) @(posedge clock);
    @(posedge clock);
    check("drain", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin2therm_gen.md
BIN2THERM_GEN -- requirements
Module: bin2therm_gen

Interface
REQ-001 Parameter bin_length, default 9: binary code width.
REQ-002 Parameter therm_length, default 128: thermometer output width.
REQ-003 Parameter repeat_length, default 16: cycles each code is held during a sweep; legal range 1..65535.
REQ-004 clock  input  1  single clock; all logic is on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 bin_in  input  bin_length  binary code to encode.
REQ-007 valid_in  input  1  bin_in is valid.
REQ-008 ready_out  output  1  block accepts bin_in this cycle.
REQ-009 start_sweep  input  1  request a full code-density sweep.
REQ-010 thermo  output  therm_length  thermometer code.
REQ-011 valid_thermo  output  1  thermo is valid.
REQ-012 sweep_busy  output  1  sweep in progress.
REQ-013 sweep_done  output  1  one-cycle pulse marking the end of a sweep.

Function
REQ-014 Encoding of value b SHALL be: thermo[k]=1 for k<b, else 0; b=0 gives all zeros; b>=therm_length saturates to all ones.
REQ-015 FSM states SHALL be IDLE and SWEEP only.
REQ-016 ready_out SHALL be combinational: (state==IDLE) and not start_sweep.
REQ-017 Handshake: a transfer occurs when valid_in and ready_out are both 1; a transfer at cycle N SHALL give valid_thermo=1 with the encoded thermo at cycle N+2.
REQ-018 Back-to-back transfers SHALL sustain one code per cycle, with no bubbles between them.
REQ-019 Cycles without a transfer SHALL give valid_thermo=0 two cycles later; thermo SHALL hold its last value.
REQ-020 IDLE->SWEEP: on start_sweep=1 in IDLE; start_sweep takes priority over valid_in in the same cycle, and that valid_in is not accepted.
REQ-021 In SWEEP the block SHALL emit codes 0,1,...,therm_length in ascending order.
REQ-022 Each sweep code SHALL be presented for repeat_length consecutive cycles with valid_thermo=1.
REQ-023 Sweep output timing: first sweep code at cycle N+2 after the start cycle N; total (therm_length+1)*repeat_length valid cycles, contiguous.
REQ-024 Counter widths: code counter bin_length+1 bits; repeat counter 16 bits; neither counter SHALL wrap within a sweep.
REQ-025 SWEEP->IDLE: after the last code is issued into the pipeline.
REQ-026 sweep_done SHALL pulse together with the final valid_thermo of the sweep.
REQ-027 sweep_busy SHALL be 1 from the cycle after start until the sweep_done cycle, inclusive.
REQ-028 start_sweep during SWEEP SHALL be ignored.
REQ-029 valid_in during SWEEP SHALL be ignored, and ready_out=0.

Reset
REQ-030 While reset=1, thermo, valid_thermo, sweep_busy and sweep_done SHALL be 0, state SHALL be IDLE, and both counters SHALL be 0.
REQ-031 Reset asserted mid-sweep SHALL abort the sweep with no sweep_done pulse and flush any in-flight pipeline data.

Configuration
REQ-032 With macro THERM_BUBBLE_INJECT_EN defined, the block SHALL add these inputs:
- bubble_en (1 bit);
- bubble_pos (log2(therm_length) bits).
REQ-033 With THERM_BUBBLE_INJECT_EN defined and bubble_en=1 when a code enters the pipeline, thermo[bubble_pos] of that code SHALL be inverted at the output; latency is unchanged.
REQ-034 Without THERM_BUBBLE_INJECT_EN, the ports and the inversion logic SHALL be absent.

Structure
REQ-035 Package therm_pkg SHALL hold the FSM state typedef and the default width constants (9, 128, 16).
REQ-036 Sub-module bin2therm_enc SHALL implement the saturating encode plus the first pipeline register; bin2therm_gen instantiates it once.

Verification (therm_length=128, repeat_length=16)
REQ-037 Single transfer: bin_in=5 accepted at cycle 10 -> cycle 12: thermo=0x1F, valid_thermo=1; cycle 13: valid_thermo=0.
REQ-038 Boundary codes: bin_in=0, 128, 300 on consecutive cycles -> all zeros, all ones, all ones on three consecutive valid cycles.
REQ-039 Sweep: start_sweep at cycle 0 -> first code 0 at cycle 2, 2064 contiguous valid cycles, code 128 in the final 16 cycles, sweep_done on the last.
REQ-040 Priority: start_sweep=1 and valid_in=1 in the same IDLE cycle -> ready_out=0, bin_in is dropped, and the sweep runs.
REQ-041 Reset at sweep cycle 500 -> all outputs 0 next edge, no sweep_done; a new transfer after release works with latency 2.
REQ-042 THERM_BUBBLE_INJECT_EN: bin_in=10, bubble_en=1, bubble_pos=4 -> thermo=0x3EF.
